fpu_sp_subtractor_seq: RTL and testbench
========================================

Name: fpu_sp_subtractor_seq

Overview:
Multi-cycle IEEE-754 single-precision subtractor computing result = a - b with valid/ready handshakes on input and output. It is the inverse-operation companion to the combinational single-precision adder. It uses the same unpack / align / signed-magnitude add / normalize / pack flow, spread across FSM states. Normalization shifts iteratively, one bit per cycle, so result latency depends on the data.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored mantissa width (hidden bit excluded)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operand pair present
in_ready  output  1  block can accept operands
a  input  32  minuend, IEEE-754 single
b  input  32  subtrahend, IEEE-754 single
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
result  output  32  a - b, IEEE-754 single
overflow_underflow_flag  output  1  exponent overflow/underflow or special input; valid with out_valid
busy  output  1  high in any state other than IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: state=IDLE; in_ready=1; out_valid=0; result=32'h0; overflow_underflow_flag=0; busy=0. Reset in any state aborts the operation; no output is produced for it.
- FSM states: IDLE, ALIGN, ADD, NORM, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid, register a and b; b's sign is inverted here, so the operation becomes a + (-b).
  - If either input exponent is 8'hFF: result=32'h7FC00000, flag=1, go to DONE.
  - An input with exponent 0 is treated as ±0 (denormals flushed).
  - If both inputs are zero: result=32'h0, go to DONE.
  - If only b is zero: result=a, go to DONE.
  - If only a is zero: result={~b[31], b[30:0]}, go to DONE.
  - Otherwise go to ALIGN.
- ALIGN (1 cycle):
  - Operand1 is the operand with the larger exponent; on equal exponents it is a.
  - Mantissas are {1'b1, man}, 24 bits.
  - Operand2's mantissa is shifted right by the exponent difference. A difference of 24 or more gives 0. Shifted-out bits are discarded (truncation, no rounding).
  - Working exponent = the larger exponent.
- ADD (1 cycle), producing a 25-bit magnitude:
  - Equal signs: sum = m1 + m2; sign = common sign.
  - Differing signs: sum = |m1 - m2|; sign = sign of the larger magnitude.
  - Magnitude zero: result=32'h0, flag=0, go to DONE (NORM skipped).
  - Otherwise go to NORM.
- NORM, one action per cycle:
  - If bit24=1: shift right 1, exp+1. If exp becomes 255: result={sign, 8'hFF, 23'h0}, flag=1, go to DONE.
  - Else if bit23=0: shift left 1, exp-1. If exp becomes 0: result={sign, 31'h0}, flag=1, go to DONE.
  - Else: pack {sign, exp, mag[22:0]}, flag=0, go to DONE.
  - NORM takes 1 to 24 cycles.
- DONE:
  - out_valid=1; result and flag are held stable while out_ready=0.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
  - in_ready is low in every state except IDLE, so there is no overlap between operations.
- Latency from the in_valid&in_ready edge to out_valid:
  - Special/zero inputs: 1 cycle.
  - Zero difference: 3 cycles.
  - Normal path: 3 + NORM cycles.
- Sign rule: an exact-cancellation result is +0 regardless of operand signs.

Test Plan:
- 0x40400000 - 0x3F800000 (3.0-1.0) -> result 0x40000000, flag 0, out_valid 4 cycles after accept.
- 0x3F800000 - 0x3F400000 (1.0-0.75) -> 0x3E800000 (0.25), flag 0, NORM performs 2 left shifts, out_valid 6 cycles after accept.
- 0x3F800000 - 0xBF800000 (1.0-(-1.0)) -> 0x40000000, carry path (right shift, exp+1); 0x3F800000 - 0x3F800000 -> 0x00000000, flag 0, out_valid 3 cycles after accept.
- 0x7F7FFFFF - 0xFF7FFFFF -> 0x7F800000, flag 1; a=0x7F800000, b=0x3F800000 -> 0x7FC00000, flag 1, out_valid 1 cycle after accept.
- Backpressure: out_ready low for 5 cycles in DONE -> result/out_valid stable, in_ready=0 and new in_valid ignored; out_ready high -> IDLE next cycle, in_ready=1.
- Assert rst during NORM (1.0-0.75 case) -> outputs return to reset values immediately; next operation 0x40400000-0x3F800000 returns 0x40000000 correctly.

Source files
------------

// File: rtl/fpu_sp_subtractor_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor, result = a - b.
// Unpack / align / signed-magnitude add / one-bit-per-cycle normalize.
module fpu_sp_subtractor_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   overflow_underflow_flag,
    output logic                   busy
);

    localparam int W  = EXP_W + MAN_W + 1;
    localparam int MW = MAN_W + 1;
    localparam logic [EXP_W-1:0] EMAX  = '1;
    localparam logic [EXP_W-1:0] SHMAX = EXP_W'(MW);
    localparam logic [W-1:0] QNAN =
        {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, ALIGN, ADD, NORM, DONE
    } state_t;

    state_t state_q, state_d;

    logic             s1_q, s1_d, s2_q, s2_d;
    logic [EXP_W-1:0] e1_q, e1_d, e2_q, e2_d;
    logic [MW-1:0]    m1_q, m1_d, m2_q, m2_d;
    logic             sign_q, sign_d;
    logic [MW:0]      mag_q, mag_d;
    logic [W-1:0]     res_q, res_d;
    logic             flag_q, flag_d;

    logic [EXP_W-1:0] ea, eb, diff, e_inc, e_dec;
    logic [MW:0]      sum;
    logic             a_zero, b_zero;

    assign ea     = a[W-2 -: EXP_W];
    assign eb     = b[W-2 -: EXP_W];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign e_inc  = e1_q + 1'b1;
    assign e_dec  = e1_q - 1'b1;

    always_comb begin
        state_d = state_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        e1_d    = e1_q;
        e2_d    = e2_q;
        m1_d    = m1_q;
        m2_d    = m2_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        res_d   = res_q;
        flag_d  = flag_q;
        diff    = '0;
        sum     = '0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    flag_d  = 1'b0;
                    state_d = DONE;
                    if (ea == EMAX || eb == EMAX) begin
                        res_d  = QNAN;
                        flag_d = 1'b1;
                    end else if (a_zero && b_zero) begin
                        res_d = '0;
                    end else if (b_zero) begin
                        res_d = a;
                    end else if (a_zero) begin
                        res_d = {~b[W-1], b[W-2:0]};
                    end else begin
                        // b is negated on capture: the rest is a + (-b)
                        s1_d    = a[W-1];
                        s2_d    = ~b[W-1];
                        e1_d    = ea;
                        e2_d    = eb;
                        m1_d    = {1'b1, a[MAN_W-1:0]};
                        m2_d    = {1'b1, b[MAN_W-1:0]};
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (e1_q >= e2_q) begin
                    diff = e1_q - e2_q;
                    m2_d = (diff >= SHMAX) ? '0 : (m2_q >> diff);
                end else begin
                    diff = e2_q - e1_q;
                    s1_d = s2_q;
                    s2_d = s1_q;
                    e1_d = e2_q;
                    m1_d = m2_q;
                    m2_d = (diff >= SHMAX) ? '0 : (m1_q >> diff);
                end
                state_d = ADD;
            end
            ADD: begin
                if (s1_q == s2_q) begin
                    sum    = {1'b0, m1_q} + {1'b0, m2_q};
                    sign_d = s1_q;
                end else if (m1_q >= m2_q) begin
                    sum    = {1'b0, m1_q - m2_q};
                    sign_d = s1_q;
                end else begin
                    sum    = {1'b0, m2_q - m1_q};
                    sign_d = s2_q;
                end
                mag_d = sum;
                if (sum == '0) begin
                    // exact cancellation is always +0
                    res_d   = '0;
                    flag_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    state_d = NORM;
                end
            end
            NORM: begin
                if (mag_q[MW]) begin
                    mag_d = mag_q >> 1;
                    e1_d  = e_inc;
                    if (e_inc == EMAX) begin
                        res_d   = {sign_q, EMAX, {MAN_W{1'b0}}};
                        flag_d  = 1'b1;
                        state_d = DONE;
                    end
                end else if (!mag_q[MW-1]) begin
                    mag_d = mag_q << 1;
                    e1_d  = e_dec;
                    if (e_dec == '0) begin
                        res_d   = {sign_q, {(W-1){1'b0}}};
                        flag_d  = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    res_d   = {sign_q, e1_q, mag_q[MAN_W-1:0]};
                    flag_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            e1_q    <= '0;
            e2_q    <= '0;
            m1_q    <= '0;
            m2_q    <= '0;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            res_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            e1_q    <= e1_d;
            e2_q    <= e2_d;
            m1_q    <= m1_d;
            m2_q    <= m2_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            res_q   <= res_d;
            flag_q  <= flag_d;
        end
    end

    assign in_ready                = (state_q == IDLE);
    assign out_valid               = (state_q == DONE);
    assign busy                    = (state_q != IDLE);
    assign result                  = res_q;
    assign overflow_underflow_flag = flag_q;

endmodule

// File: tb/tb_fpu_sp_subtractor_seq.sv
// Scoreboard bench for fpu_sp_subtractor_seq: directed cases plus
// random operands checked against an arithmetic reference model.
module tb_fpu_sp_subtractor_seq;

    typedef struct {
        logic [31:0] r;
        logic        f;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        flag;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hold_req = 0;

    exp_t exp_q[$];
    int   acc_q[$];

    fpu_sp_subtractor_seq dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .overflow_underflow_flag(flag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Reference: plain signed integer arithmetic on aligned mantissas
    function automatic void ref_sub(input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] r, output logic f,
                                    output int lat);
        int ex, ey, e, d, n, p;
        longint mx, my, m1, m2, s;
        logic sx, sy, sg;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        sx = x[31];
        sy = ~y[31];
        f = 1'b0;
        lat = 1;
        r = '0;
        if (ex == 255 || ey == 255) begin
            r = 32'h7FC00000;
            f = 1'b1;
            return;
        end
        if (ex == 0 && ey == 0) return;
        if (ey == 0) begin
            r = x;
            return;
        end
        if (ex == 0) begin
            r = {sy, y[30:0]};
            return;
        end
        mx = longint'({1'b1, x[22:0]});
        my = longint'({1'b1, y[22:0]});
        if (ex >= ey) begin
            e = ex;
            d = ex - ey;
            m1 = sx ? -mx : mx;
            m2 = (d >= 24) ? 0 : (my >> d);
            m2 = sy ? -m2 : m2;
        end else begin
            e = ey;
            d = ey - ex;
            m1 = sy ? -my : my;
            m2 = (d >= 24) ? 0 : (mx >> d);
            m2 = sx ? -m2 : m2;
        end
        s = m1 + m2;
        sg = (s < 0);
        if (sg) s = -s;
        lat = 3;
        if (s == 0) return;
        p = 0;
        for (int i = 0; i < 25; i++)
            if (((s >> i) & 1) != 0) p = i;
        if (p == 24) begin
            if (e + 1 == 255) begin
                r = {sg, 8'hFF, 23'h0};
                f = 1'b1;
                lat = 4;
            end else begin
                r = {sg, 8'(e + 1), 23'(s >> 1)};
                lat = 5;
            end
        end else begin
            n = 23 - p;
            if (e <= n) begin
                r = {sg, 31'h0};
                f = 1'b1;
                lat = 3 + e;
            end else begin
                r = {sg, 8'(e - n), 23'(s << n)};
                lat = 4 + n;
            end
        end
    endfunction

    task automatic send_exp(input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] r, input logic f,
                            input int lat);
        exp_t e;
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        a = x;
        b = y;
        n = 0;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got in_ready=0 want 1");
            in_valid = 1'b0;
            return;
        end
        e.r = r;
        e.f = f;
        e.lat = lat;
        exp_q.push_back(e);
        acc_q.push_back(cyc + 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        logic f;
        int lat;
        ref_sub(x, y, r, f, lat);
        send_exp(x, y, r, f, lat);
    endtask

    // Monitor: compares results, holds them under random backpressure
    logic [31:0] held_r;
    logic        held_f;
    logic        seen = 1'b0;
    logic        taken = 1'b0;
    int          hold = 0;
    exp_t        me;
    int          macc;

    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
            taken = 1'b0;
            hold = 0;
            out_ready = 1'b0;
        end else begin
            if (taken) begin
                taken = 1'b0;
                chk("idle_out_valid", 32'(out_valid), 32'd0);
                chk("idle_in_ready", 32'(in_ready), 32'd1);
            end
            if (out_valid) begin
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output got %h want none",
                                 result);
                    end else begin
                        me = exp_q.pop_front();
                        macc = acc_q.pop_front();
                        chk("result", result, me.r);
                        chk("flag", 32'(flag), 32'(me.f));
                        chk("latency", 32'(cyc - macc + 1), 32'(me.lat));
                    end
                    held_r = result;
                    held_f = flag;
                    seen = 1'b1;
                    hold = (hold_req > 0) ? hold_req : $urandom_range(0, 2);
                    hold_req = 0;
                end else begin
                    chk("hold_result", result, held_r);
                    chk("hold_flag", 32'(flag), 32'(held_f));
                end
                if (hold == 0) begin
                    out_ready = 1'b1;
                    seen = 1'b0;
                    taken = 1'b1;
                end else begin
                    out_ready = 1'b0;
                    hold--;
                end
            end else begin
                out_ready = 1'b0;
            end
        end
    end

    function automatic logic [31:0] mk(input int e);
        return {1'($urandom), 8'(e), 23'($urandom)};
    endfunction

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d pending want 0",
                     exp_q.size());
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n, k, ea, eb;
        logic [31:0] x, y;

        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_flag", 32'(flag), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        send_exp(32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 4);
        send_exp(32'h3F800000, 32'h3F400000, 32'h3E800000, 1'b0, 6);
        send_exp(32'h3F800000, 32'hBF800000, 32'h40000000, 1'b0, 5);
        send_exp(32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 3);
        send_exp(32'hBF800000, 32'hBF800000, 32'h00000000, 1'b0, 3);
        send_exp(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1, 4);
        send_exp(32'h7F800000, 32'h3F800000, 32'h7FC00000, 1'b1, 1);
        send_exp(32'h00000000, 32'h3F800000, 32'hBF800000, 1'b0, 1);
        send_exp(32'h40000000, 32'h00000000, 32'h40000000, 1'b0, 1);
        send_exp(32'h00000000, 32'h80000000, 32'h00000000, 1'b0, 1);
        send_exp(32'h00C00000, 32'h00800000, 32'h00000000, 1'b1, 4);
        send_exp(32'h4B800000, 32'h3F800000, 32'h4B800000, 1'b0, 4);
        drain();

        // Backpressure: result held, new operands refused
        hold_req = 5;
        send_exp(32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 4);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 32'h3F800000;
            b = 32'h40000000;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain();

        // Reset while normalizing aborts the operation
        send_exp(32'h3F800000, 32'h3F400000, 32'h3E800000, 1'b0, 6);
        @(negedge clk);
        @(negedge clk);
        chk("norm_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        acc_q.delete();
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_result", result, 32'h0);
        chk("arst_flag", 32'(flag), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_exp(32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 4);
        drain();

        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 15);
            ea = $urandom_range(1, 254);
            case (k)
                0: ea = 255;
                1: ea = 0;
                2, 3: ea = $urandom_range(1, 24);
                4: ea = $urandom_range(250, 254);
                default: ;
            endcase
            if (ea == 0 || ea == 255 || $urandom_range(0, 9) == 0) begin
                eb = $urandom_range(0, 255);
            end else begin
                eb = ea + int'($urandom_range(0, 6)) - 3;
                if (eb < 1) eb = 1;
                if (eb > 254) eb = 254;
            end
            x = mk(ea);
            y = mk(eb);
            k = $urandom_range(0, 9);
            if (k == 0) y = x;
            if (k == 1) y = {~x[31], x[30:0]};
            if (k == 2) y = {x[31:8], 8'($urandom)};
            send(x, y);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
